load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU: takes the ALU sum (base+offset) as the effective address,
//  performs RV32I loads/stores on a word-wide data-memory port with a req/ready handshake, and returns
//  extended load data to writeback. Multi-cycle; stalls execute via ex_ready while a memory access is outstanding.
// PARAMETERS
//  WIDTH    32   data/address width; only 32 is supported.
//  TIMEOUT  64   max cycles in ACCESS waiting for mem_ready before raising exc_bus; 0 disables the timeout.
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  ex_valid       in   1      execute presents a memory op
//  ex_ready       out  1      LSU accepts op this cycle (= state==IDLE)
//  ex_is_store    in   1      1 = store, 0 = load
//  ex_funct3      in   3      RV32I funct3 (size/sign)
//  ex_addr        in   WIDTH  effective address (ALU out)
//  ex_wdata       in   WIDTH  store data (rs2)
//  ex_rd          in   5      load destination register
//  mem_req        out  1      bus request, held until mem_ready
//  mem_we         out  1      write enable
//  mem_addr       out  WIDTH  word-aligned address ({addr[31:2],2'b00})
//  mem_be         out  4      byte enables
//  mem_wdata      out  WIDTH  lane-replicated store data
//  mem_ready      in   1      completes the current request; mem_rdata valid this cycle
//  mem_rdata      in   WIDTH  read word
//  wb_valid       out  1      one-cycle pulse: load result valid
//  wb_rd          out  5      destination register
//  wb_data        out  WIDTH  extended load data
//  exc_valid      out  1      one-cycle pulse: exception
//  exc_cause      out  2      0 = misaligned, 1 = illegal funct3, 2 = bus timeout
//  exc_addr       out  WIDTH  faulting effective address
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, mem_be, wb_valid, exc_valid = 0; all data regs = 0.
//   Reset mid-access drops mem_req immediately; the outstanding op is discarded with no wb/exc.
//  FSM: IDLE -> ACCESS | FAULT;  ACCESS -> DONE (mem_ready) | FAULT (timeout);  DONE -> IDLE;  FAULT -> IDLE.
//  IDLE: ex_ready=1. On ex_valid, latch op. Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
//   stores 000 SB, 001 SH, 010 SW. Any other funct3 -> FAULT, cause 1. Misaligned (H with addr[0]=1,
//   W with addr[1:0]!=0) -> FAULT, cause 0; illegal is checked before misaligned. Otherwise -> ACCESS.
//  ACCESS: mem_req=1; mem_addr/mem_we/mem_be/mem_wdata are registered and stable until mem_ready.
//   mem_be: B = 1<<addr[1:0], H = 2'b11<<addr[1:0], W = 4'hF (loads drive the same be).
//   mem_wdata: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
//   Timeout counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready;
//   at count==TIMEOUT-1 with no mem_ready -> FAULT, cause 2. mem_ready in the expiry cycle wins (no fault).
//  DONE (1 cycle): load -> wb_valid=1 with wb_data = lane selected by addr[1:0] (B) / addr[1] (H),
//   sign-extended (LB/LH) or zero-extended (LBU/LHU); store -> no wb pulse.
//  FAULT (1 cycle): exc_valid=1, exc_cause, exc_addr = latched address; no bus activity.
//  Latency: accept at edge N; mem_req high in cycle N+1; mem_ready in cycle M -> wb_valid in cycle M+1.
//   Next op is accepted in the cycle after DONE/FAULT. Minimum issue interval is 3 cycles.
//  mem_ready outside ACCESS is ignored. wb_data/wb_rd hold their last values when wb_valid=0.
//  ex_valid while not IDLE is ignored (ex_ready=0). Execute must hold its inputs until accepted.
// STRUCTURE
//  cpu_pkg: lsu_state_t enum {IDLE,ACCESS,DONE,FAULT}; funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
//   exc_cause constants EXC_MISALIGN/EXC_ILLEGAL/EXC_BUSTO.
//  Sub-module load_extend (combinational): rdata, addr[1:0], funct3 -> extended WIDTH-bit result.
//  Store lane alignment and the FSM/timeout stay in this module.
// TESTING
//  LW addr 0x100, mem_ready after 2 cycles with rdata 0xDEADBEEF -> mem_be=F, wb_data=0xDEADBEEF, wb_rd correct.
//  LB addr 0x103, rdata 0x80FF1234 -> mem_be=8, wb_data=0xFFFFFF80; same with LBU -> 0x00000080.
//  SH addr 0x202, wdata 0x0000ABCD -> mem_addr=0x200, mem_be=C, mem_wdata=0xABCDABCD, we=1, no wb_valid.
//  LW addr 0x101 -> no mem_req, exc_valid with cause 0 and exc_addr=0x101; funct3=011 -> cause 1.
//  TIMEOUT=4, mem_ready held low -> exactly 4 mem_req cycles, then exc cause 2; mem_ready on 4th cycle -> normal DONE.
//  rst_n pulled low during ACCESS -> mem_req low same cycle, no wb/exc, ex_ready=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings, exception causes and funct3 decode helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_MISALIGN = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
  localparam logic [1:0] EXC_BUSTO    = 2'd2;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  // funct3[1:0] encodes access size for every legal op: 00 byte, 01 half, 10 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to the load funct3.
module load_extend
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [1:0]       off_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {24'h000000, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result_o = {16'h0000, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: validates and issues loads/stores on a word-wide
// req/ready bus, returns extended load data and flags misaligned/illegal/timeout faults.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_is_store,
  input  logic [2:0]       ex_funct3,
  input  logic [WIDTH-1:0] ex_addr,
  input  logic [WIDTH-1:0] ex_wdata,
  input  logic [4:0]       ex_rd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [WIDTH-1:0] exc_addr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t       state_q;
  logic             op_store_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q;
  logic [4:0]       rd_q;
  logic [TW-1:0]    tcnt_q;
  logic             mem_req_q, mem_we_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic             wb_valid_q, exc_valid_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_data_q, exc_addr_q;
  logic [1:0]       exc_cause_q;

  logic [3:0]       be_d;
  logic [WIDTH-1:0] wdata_d;
  logic [WIDTH-1:0] ld_ext;
  logic             timeout_hit;

  // Byte enables and lane-replicated store data for the op being presented.
  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ex_addr[1:0];
        wdata_d = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << ex_addr[1:0];
        wdata_d = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wdata_d = ex_wdata;
      end
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .rdata_i  (mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .result_o (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_store_q  <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      rd_q        <= '0;
      tcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            op_store_q <= ex_is_store;
            f3_q       <= ex_funct3;
            addr_q     <= ex_addr;
            rd_q       <= ex_rd;
            // Illegal encoding takes priority over alignment.
            if (!f3_legal(ex_is_store, ex_funct3)) begin
              state_q     <= FAULT;
              exc_valid_q <= 1'b1;
              exc_cause_q <= EXC_ILLEGAL;
              exc_addr_q  <= ex_addr;
            end else if (f3_misaligned(ex_funct3, ex_addr[1:0])) begin
              state_q     <= FAULT;
              exc_valid_q <= 1'b1;
              exc_cause_q <= EXC_MISALIGN;
              exc_addr_q  <= ex_addr;
            end else begin
              state_q     <= ACCESS;
              tcnt_q      <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ex_is_store;
              mem_addr_q  <= {ex_addr[WIDTH-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ACCESS: begin
          // A response arriving in the expiry cycle still completes normally.
          if (mem_ready) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            if (!op_store_q) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= ld_ext;
            end
          end else if (timeout_hit) begin
            state_q     <= FAULT;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            exc_valid_q <= 1'b1;
            exc_cause_q <= EXC_BUSTO;
            exc_addr_q  <= addr_q;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4): loads, stores, lane
// extension, faults, bus timeout and asynchronous reset during an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  int errors = 0;
  int checks = 0;
  int req_cycles;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_store (ex_is_store),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .exc_addr    (exc_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an op for one accepting edge; afterwards the DUT is in ACCESS or FAULT.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_wdata    = wd;
    ex_rd       = rd;
    ex_valid    = 1'b1;
    step();
    ex_valid    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd_word);
    mem_ready = 1'b1;
    mem_rdata = rd_word;
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'b0;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    #2 rst_n = 1'b1;
    step();

    // LW 0x100, response on the second ACCESS cycle
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_ex_ready", 32'(ex_ready), 32'd0);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_be", 32'(mem_be), 32'hF);
    chk("lw_we", 32'(mem_we), 32'd0);
    step();
    chk("lw_req_hold", 32'(mem_req), 32'd1);
    respond(32'hDEADBEEF);
    chk("lw_wb_valid", 32'(wb_valid), 32'd1);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wb_rd", 32'(wb_rd), 32'd5);
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    step();
    chk("lw_wb_pulse", 32'(wb_valid), 32'd0);
    chk("lw_ready_again", 32'(ex_ready), 32'd1);
    chk("lw_wb_hold", wb_data, 32'hDEADBEEF);

    // LB / LBU at 0x103: top byte 0x80
    issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd7);
    chk("lb_be", 32'(mem_be), 32'h8);
    chk("lb_addr", mem_addr, 32'h100);
    respond(32'h80FF1234);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_rd", 32'(wb_rd), 32'd7);
    step();
    issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd8);
    respond(32'h80FF1234);
    chk("lbu_data", wb_data, 32'h00000080);
    step();

    // LH / LHU at 0x102: upper half 0x8001
    issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd9);
    chk("lh_be", 32'(mem_be), 32'hC);
    respond(32'h80015555);
    chk("lh_data", wb_data, 32'hFFFF8001);
    step();
    issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd9);
    respond(32'h80015555);
    chk("lhu_data", wb_data, 32'h00008001);
    step();

    // SH 0x202
    issue(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd3);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(mem_we), 32'd1);
    respond(32'h0);
    chk("sh_no_wb", 32'(wb_valid), 32'd0);
    chk("sh_wb_hold", wb_data, 32'h00008001);
    step();

    // SB 0x201: byte lane 1, replicated data
    issue(1'b1, 3'b000, 32'h201, 32'h123456A5, 5'd3);
    chk("sb_be", 32'(mem_be), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    respond(32'h0);
    step();

    // Misaligned LW
    issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd4);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_exc", 32'(exc_valid), 32'd1);
    chk("mis_cause", 32'(exc_cause), 32'd0);
    chk("mis_addr", exc_addr, 32'h101);
    step();
    chk("mis_exc_pulse", 32'(exc_valid), 32'd0);
    chk("mis_ready", 32'(ex_ready), 32'd1);

    // Illegal load funct3=011
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd4);
    chk("ill_exc", 32'(exc_valid), 32'd1);
    chk("ill_cause", 32'(exc_cause), 32'd1);
    chk("ill_req", 32'(mem_req), 32'd0);
    step();

    // Store funct3=100 at odd address: illegal wins over misaligned
    issue(1'b1, 3'b100, 32'h105, 32'h0, 5'd4);
    chk("illst_cause", 32'(exc_cause), 32'd1);
    chk("illst_addr", exc_addr, 32'h105);
    step();

    // mem_ready while IDLE is ignored
    respond(32'h11111111);
    chk("idle_ready_wb", 32'(wb_valid), 32'd0);
    chk("idle_ready_exc", 32'(exc_valid), 32'd0);

    // Timeout: mem_ready never comes
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd2);
    req_cycles = 0;
    for (int i = 0; i < 10 && mem_req; i++) begin
      req_cycles++;
      step();
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd4);
    chk("to_exc", 32'(exc_valid), 32'd1);
    chk("to_cause", 32'(exc_cause), 32'd2);
    chk("to_addr", exc_addr, 32'h300);
    chk("to_no_wb", 32'(wb_valid), 32'd0);
    step();

    // mem_ready on the 4th ACCESS cycle completes normally
    issue(1'b0, 3'b010, 32'h304, 32'h0, 5'd6);
    step(); step(); step();
    chk("to4_req", 32'(mem_req), 32'd1);
    respond(32'hCAFEF00D);
    chk("to4_wb", 32'(wb_valid), 32'd1);
    chk("to4_no_exc", 32'(exc_valid), 32'd0);
    chk("to4_data", wb_data, 32'hCAFEF00D);
    step();

    // Asynchronous reset during ACCESS
    issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd1);
    chk("ar_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(mem_req), 32'd0);
    step();
    #3 rst_n = 1'b1;
    step();
    chk("ar_ex_ready", 32'(ex_ready), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h99999999;
    step();
    mem_ready = 1'b0;
    chk("ar_no_wb", 32'(wb_valid), 32'd0);
    chk("ar_no_exc", 32'(exc_valid), 32'd0);
    chk("ar_wb_data", wb_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
